// File: rtl/instruction_encoder.sv
// Packs instruction fields into 32-bit IR words and streams them into program memory.
// Optional: define ENCODER_CHECKSUM_EN to add o_checksum (XOR of completed words).
module instruction_encoder #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [7:0]            i_opcode,
  input  logic [3:0]            i_rs1,
  input  logic [3:0]            i_rs2,
  input  logic [3:0]            i_ws,
  input  logic [15:0]           i_i,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_error
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]           o_checksum
`endif
);

  localparam logic [7:0] OpNop = 8'd0;
  localparam logic [7:0] OpLda = 8'd1;
  localparam logic [7:0] OpSta = 8'd2;
  localparam logic [7:0] OpAdd = 8'd3;
  localparam logic [7:0] OpSub = 8'd4;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = 1;
  localparam logic [ADDR_WIDTH:0]   CountOne = 1;

  typedef enum logic [1:0] {StIdle, StPend, StFull} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           data_q, data_d;
  logic                  error_q, error_d;
  logic                  ready_en_q;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        accept;
  logic        complete;

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (i_opcode)
      OpNop:        enc_word = '0;
      OpLda:        enc_word = {i_opcode, i_ws, 4'b0, i_i};
      OpSta:        enc_word = {i_opcode, i_rs1, 4'b0, i_i};
      OpAdd, OpSub: enc_word = {i_opcode, i_ws, 12'b0, i_rs1, i_rs2};
      default:      enc_err  = 1'b1;
    endcase
  end

  assign o_mem_we   = (state_q == StPend);
  assign o_full     = (state_q == StFull);
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
  assign o_count    = count_q;
  assign o_error    = error_q;

  // The final word's completion cycle cannot also accept: there is no address left for it.
  assign o_ready = ready_en_q && !o_full && !i_clear &&
                   (!o_mem_we || (i_mem_ready && addr_q != LastAddr));

  assign accept   = i_valid && o_ready;
  assign complete = o_mem_we && i_mem_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    error_d = error_q;
    if (i_clear) begin
      state_d = StIdle;
      addr_d  = '0;
      count_d = '0;
      data_d  = '0;
      error_d = 1'b0;
    end else begin
      if (complete) begin
        count_d = count_q + CountOne;
        if (addr_q == LastAddr) begin
          state_d = StFull;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StIdle;
        end
      end
      if (accept) begin
        data_d  = enc_word;
        error_d = error_q | enc_err;
        state_d = StPend;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      error_q    <= error_d;
      ready_en_q <= 1'b1;
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (i_clear) begin
      checksum_d = '0;
    end else if (complete) begin
      checksum_d = checksum_q ^ data_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign o_checksum = checksum_q;
`endif

endmodule
